// File: rtl/multicycle_control.sv
// Moore control FSM sequencing the multicycle MIPS datapath (lw, sw, R-type, beq, j).
// Define MCCTRL_ADDI_EN to build the ADDIEX/ADDIWB path for addi; otherwise addi decodes as illegal.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       op_legal;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MCCTRL_ADDI_EN
      OP_ADDI:                              op_legal = 1'b1;
`endif
      default:                              op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
`ifdef MCCTRL_ADDI_EN
          OP_ADDI:        state_d = S_ADDIEX;
`endif
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MCCTRL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Outputs depend only on state (plus mem_ready in memory states); reset forces all of them low.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~op_legal;
          instr_done = ~op_legal;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
`ifdef MCCTRL_ADDI_EN
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected state and control word,
// a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Word layout: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite}_{MemtoReg,RegWrite,RegDst,ALUSrcA}_
  //              ALUSrcB_ALUOp_PCSource_{instr_done,illegal_op}
  localparam logic [17:0] W_ZERO   = 18'b000000_0000_00_00_00_00;
  localparam logic [17:0] W_FET_NR = 18'b000100_0000_01_00_00_00;
  localparam logic [17:0] W_FET_RD = 18'b100101_0000_01_00_00_00;
  localparam logic [17:0] W_DEC    = 18'b000000_0000_11_00_00_00;
  localparam logic [17:0] W_DEC_IL = 18'b000000_0000_11_00_00_11;
  localparam logic [17:0] W_MEMADR = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] W_MEMRD  = 18'b001100_0000_00_00_00_00;
  localparam logic [17:0] W_MEMWB  = 18'b000000_1100_00_00_00_10;
  localparam logic [17:0] W_MWR_NR = 18'b001010_0000_00_00_00_00;
  localparam logic [17:0] W_MWR_RD = 18'b001010_0000_00_00_00_10;
  localparam logic [17:0] W_EXEC   = 18'b000000_0001_00_10_00_00;
  localparam logic [17:0] W_ALUWB  = 18'b000000_0110_00_00_00_10;
  localparam logic [17:0] W_BRANCH = 18'b010000_0001_00_01_01_10;
  localparam logic [17:0] W_JUMP   = 18'b100000_0000_00_00_10_10;
`ifdef MCCTRL_ADDI_EN
  localparam logic [17:0] W_ADDIEX = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] W_ADDIWB = 18'b000000_0100_00_00_00_10;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  logic [21:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_cyc = 0;
  logic [17:0] act_word;

  assign act_word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                     instr_done, illegal_op};

  task automatic cyc(input logic r, input logic [5:0] op, input logic m,
                     input logic [3:0] es, input logic [17:0] ew);
    @(posedge clk);
    #1;
    reset     = r;
    opcode    = op;
    mem_ready = m;
    exp_q.push_back({es, ew});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      n_cyc++;
      n_checks++;
      if (state === e[21:18]) n_pass++;
      else $display("FAIL state cyc=%0d actual=%0d required=%0d", n_cyc, state, e[21:18]);
      n_checks++;
      if (act_word === e[17:0]) n_pass++;
      else $display("FAIL ctrl cyc=%0d state=%0d actual=%b required=%b", n_cyc, state, act_word, e[17:0]);
      $display("cyc %0d rst=%0b op=%b mr=%0b state=%0d ctrl=%b", n_cyc, reset, opcode, mem_ready, state, act_word);
    end
  end

  initial begin
    // Reset held: outputs forced low, state register cleared
    cyc(1, LW, 1, 4'd0, W_ZERO);
    // lw, mem_ready always 1: 5 cycles
    cyc(0, LW, 1, 4'd0, W_FET_RD);
    cyc(0, LW, 1, 4'd1, W_DEC);
    cyc(0, LW, 1, 4'd2, W_MEMADR);
    cyc(0, LW, 1, 4'd3, W_MEMRD);
    cyc(0, LW, 1, 4'd4, W_MEMWB);
    // sw with two wait cycles in MEMWR: 6 cycles
    cyc(0, SW, 1, 4'd0, W_FET_RD);
    cyc(0, SW, 1, 4'd1, W_DEC);
    cyc(0, SW, 1, 4'd2, W_MEMADR);
    cyc(0, SW, 0, 4'd5, W_MWR_NR);
    cyc(0, SW, 0, 4'd5, W_MWR_NR);
    cyc(0, SW, 1, 4'd5, W_MWR_RD);
    // FETCH stalled 3 cycles, then R-type; opcode wiggles in EXEC are ignored
    cyc(0, RT, 0, 4'd0, W_FET_NR);
    cyc(0, RT, 0, 4'd0, W_FET_NR);
    cyc(0, RT, 0, 4'd0, W_FET_NR);
    cyc(0, RT, 1, 4'd0, W_FET_RD);
    cyc(0, RT, 0, 4'd1, W_DEC);
    cyc(0, BAD, 0, 4'd6, W_EXEC);
    cyc(0, JMP, 1, 4'd7, W_ALUWB);
    // beq and j: 3 cycles each
    cyc(0, BEQ, 1, 4'd0, W_FET_RD);
    cyc(0, BEQ, 1, 4'd1, W_DEC);
    cyc(0, BEQ, 0, 4'd8, W_BRANCH);
    cyc(0, JMP, 1, 4'd0, W_FET_RD);
    cyc(0, JMP, 1, 4'd1, W_DEC);
    cyc(0, JMP, 0, 4'd9, W_JUMP);
    // illegal opcode: 2 cycles
    cyc(0, BAD, 1, 4'd0, W_FET_RD);
    cyc(0, BAD, 1, 4'd1, W_DEC_IL);
    // addi depends on build option
    cyc(0, ADDI, 1, 4'd0, W_FET_RD);
`ifdef MCCTRL_ADDI_EN
    cyc(0, ADDI, 1, 4'd1, W_DEC);
    cyc(0, ADDI, 1, 4'd10, W_ADDIEX);
    cyc(0, ADDI, 1, 4'd11, W_ADDIWB);
`else
    cyc(0, ADDI, 1, 4'd1, W_DEC_IL);
`endif
    // lw interrupted by reset during a stalled MEMRD
    cyc(0, LW, 1, 4'd0, W_FET_RD);
    cyc(0, LW, 1, 4'd1, W_DEC);
    cyc(0, LW, 0, 4'd2, W_MEMADR);
    cyc(0, LW, 0, 4'd3, W_MEMRD);
    cyc(1, LW, 0, 4'd3, W_ZERO);
    cyc(0, LW, 1, 4'd0, W_FET_RD);
    cyc(0, LW, 1, 4'd1, W_DEC);
    cyc(0, LW, 1, 4'd2, W_MEMADR);
    cyc(0, LW, 1, 4'd3, W_MEMRD);
    cyc(0, LW, 1, 4'd4, W_MEMWB);
    cyc(0, LW, 0, 4'd0, W_FET_NR);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM that sequences the team's MIPS datapath in multicycle mode: one shared memory port, IR/A/B/ALUOut holding registers, a single ALU reused across cycles. It sits beside `datapath`, takes the IR opcode and a memory-ready handshake, and drives every mux select and write enable, so the datapath never needs per-instruction control logic. It also exposes state and an instruction-retired strobe for the testbench.

## Interface
- No parameters; state encoding is fixed (see Operation).
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct field
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state, debug
- instr_done  out  1  one-cycle pulse on last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for unsupported opcode

## Operation
- States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 ALUWB, 8 BRANCH, 9 JUMP, 10 ADDIEX, 11 ADDIWB; 12-15 unreachable, decode to FETCH next.
- Unlisted outputs are 0 in each state.
- FETCH: MemRead=1, ALUSrcB=01; IRWrite=PCWrite=1 only when mem_ready=1; stay until mem_ready, then DECODE.
- DECODE: ALUSrcB=11 (branch target into ALUOut). Next by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX (macro-dependent), else FETCH with illegal_op=1 and instr_done=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10; ->MEMRD if lw, ->MEMWR if sw.
- MEMRD: MemRead=1, IorD=1; stay until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; ->FETCH.
- MEMWR: MemWrite=1, IorD=1; stay until mem_ready; instr_done=mem_ready; then FETCH.
- EXEC: ALUSrcA=1, ALUOp=10; ->ALUWB. ALUWB: RegWrite=1, RegDst=1, instr_done=1; ->FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; ->FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1; ->FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1; ->FETCH.
- opcode sampled only in DECODE and MEMADR; changes elsewhere ignored.

## Timing
- Only state is registered; outputs are combinational from state (plus mem_ready qualification in FETCH/MEMRD/MEMWR).
- reset=1: state<=0 on next edge; while reset is high all outputs forced 0 (state output shows register value), including write enables; reset mid-access abandons it.
- Cycles with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
- mem_ready ignored in all other states.
- instr_done and illegal_op never high for more than one consecutive cycle per instruction.

## Configuration
- MCCTRL_ADDI_EN defined: opcode 001000 executes via ADDIEX/ADDIWB.
- Undefined: states 10/11 not built; 001000 treated as illegal (illegal_op pulse, ->FETCH, no register write).

## Test plan
- lw (100011), mem_ready=1 after reset release: state 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done pulses in state 4.
- sw (101011), mem_ready low 2 cycles in MEMWR: state 5 held 3 cycles with MemWrite=1, IorD=1; instr_done only on the ready cycle; total 6 cycles.
- FETCH with mem_ready=0 for 3 cycles: IRWrite=PCWrite=0 throughout, both 1 on the ready cycle, then state 1.
- beq (000100): BRANCH shows PCWriteCond=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01; j (000010): PCWrite=1, PCSource=10; both 3 cycles.
- opcode 111111: illegal_op=1 for one cycle in state 1, next state 0, no RegWrite/MemWrite; addi 001000 identical when MCCTRL_ADDI_EN undefined, else 4-cycle ADDIEX/ADDIWB with RegWrite in state 11.
- reset asserted while in MEMRD with mem_ready=0: all outputs 0 immediately, state=0 after edge, FETCH resumes one cycle after reset drops.
